// File: rtl/picc_pkg.sv
// picc_pkg: shared PIC constants, register addresses and helpers
package picc_pkg;
  localparam int PICC_NUM_IRQ = 8;
  localparam int PICC_IRQ_NO_W = 3;
  localparam logic [2:0] PICC_ADDR_MASK = 3'd0;
  localparam logic [2:0] PICC_ADDR_PRI_NO = 3'd1;
  localparam logic [2:0] PICC_ADDR_IRQ_NO = 3'd2;
  localparam logic [2:0] PICC_ADDR_EDGE_MODE = 3'd3;
  localparam logic [2:0] PICC_ADDR_POL = 3'd4;
  localparam logic [2:0] PICC_ADDR_PEND_CLR = 3'd5;
  function automatic logic [PICC_NUM_IRQ-1:0] picc_onehot(input logic [PICC_IRQ_NO_W-1:0] n);
    return PICC_NUM_IRQ'(1) << n;
  endfunction
endpackage

// File: rtl/picc_irq_line.sv
// picc_irq_line: one interrupt line - synchroniser, optional debounce, edge latch, overrun
// Ports: clk, rst (sync, active-high); irq_raw async line; pol/edge_mode line config;
//   arm enables edge detection; clr_this/clr_all clear requests;
//   ir_out, pending, overrun registered line status.
// Debounce filter built only when PICC_DEBOUNCE_EN is defined.
module picc_irq_line #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  input  logic pol,
  input  logic edge_mode,
  input  logic arm,
  input  logic clr_this,
  input  logic clr_all,
  output logic ir_out,
  output logic pending,
  output logic overrun
);
  logic [SYNC_STAGES-1:0] sync;
  logic f, prev, c, rise, pend_n;
  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_param
    $error("picc_irq_line: parameter out of range");
  end
  always_ff @(posedge clk)
    sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], irq_raw};
`ifdef PICC_DEBOUNCE_EN
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      f <= 1'b0;
      cnt <= '0;
    end else if (sync[SYNC_STAGES-1] == f) cnt <= '0;
    else if (cnt == 8'(DB_CYCLES - 1)) begin
      f <= sync[SYNC_STAGES-1];
      cnt <= '0;
    end else cnt <= cnt + 8'd1;
`else
  assign f = sync[SYNC_STAGES-1];
`endif
  // prev holds the unpolarised filtered level, so a pol flip never looks like an edge
  assign c = f ^ pol;
  assign rise = arm & edge_mode & c & (f ^ prev);
  assign pend_n = edge_mode & (rise | (pending & ~clr_this & ~clr_all));
  always_ff @(posedge clk)
    if (rst) begin
      prev <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
      ir_out <= 1'b0;
    end else begin
      prev <= f;
      pending <= pend_n;
      overrun <= ~clr_all & (overrun | (rise & pending & ~clr_this));
      ir_out <= edge_mode ? pend_n : c;
    end
endmodule

// File: rtl/picc_irq_cond.sv
// picc_irq_cond: conditions raw interrupt lines for the PIC priority resolver
// Ports: clk, rst (sync, active-high); irq_raw[7:0] async lines; pol/edge_mode per-line config;
//   clr_valid/clr_no clear one pending bit; clr_all clears all pending and overrun bits;
//   ir_out -> ir0..ir7, pending edge latches, overrun sticky lost-edge flags.
// Optional debounce enabled by defining PICC_DEBOUNCE_EN.
module picc_irq_cond
  import picc_pkg::*;
#(
  parameter int NUM_IRQ = PICC_NUM_IRQ,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IRQ-1:0]       irq_raw,
  input  logic [NUM_IRQ-1:0]       pol,
  input  logic [NUM_IRQ-1:0]       edge_mode,
  input  logic                     clr_valid,
  input  logic [PICC_IRQ_NO_W-1:0] clr_no,
  input  logic                     clr_all,
  output logic [NUM_IRQ-1:0]       ir_out,
  output logic [NUM_IRQ-1:0]       pending,
  output logic [NUM_IRQ-1:0]       overrun
);
  localparam logic [7:0] ARM_N = 8'(SYNC_STAGES + 1);
  logic [7:0] arm_cnt;
  logic arm;
  logic [NUM_IRQ-1:0] clr_vec;
  // edges are ignored until the synchronisers hold post-reset data
  assign arm = arm_cnt == ARM_N;
  always_ff @(posedge clk)
    if (rst) arm_cnt <= '0;
    else if (!arm) arm_cnt <= arm_cnt + 8'd1;
  assign clr_vec = clr_valid ? picc_onehot(clr_no) : '0;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    picc_irq_line #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_line (
      .clk(clk),
      .rst(rst),
      .irq_raw(irq_raw[i]),
      .pol(pol[i]),
      .edge_mode(edge_mode[i]),
      .arm(arm),
      .clr_this(clr_vec[i]),
      .clr_all(clr_all),
      .ir_out(ir_out[i]),
      .pending(pending[i]),
      .overrun(overrun[i])
    );
  end
endmodule

// File: tb/tb_picc_irq_cond.sv
// tb_picc_irq_cond: directed self-checking bench for picc_irq_cond
module tb_picc_irq_cond;
`ifdef PICC_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;
  localparam int PW = DB == 0 ? 1 : DB + 2;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] irq_raw, pol, edge_mode, ir_out, pending, overrun;
  logic clr_valid, clr_all;
  logic [2:0] clr_no;
  int n_chk = 0;
  int n_fail = 0;
  picc_irq_cond #(.NUM_IRQ(8), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .irq_raw(irq_raw),
    .pol(pol),
    .edge_mode(edge_mode),
    .clr_valid(clr_valid),
    .clr_no(clr_no),
    .clr_all(clr_all),
    .ir_out(ir_out),
    .pending(pending),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // raise lines m for PW cycles; returns just before the edge that latches the rise
  task automatic pulse(input logic [7:0] m);
    irq_raw = irq_raw | m;
    step(PW);
    irq_raw = irq_raw & ~m;
    step(LAT - 1 - PW);
  endtask
  initial begin
    rst = 1'b1;
    pol = 8'hFF;
    irq_raw = 8'hFF;
    edge_mode = 8'hFF;
    clr_valid = 1'b0;
    clr_no = 3'd0;
    clr_all = 1'b0;
    step(2);
    chk("rst_ir", ir_out, 8'h00);
    chk("rst_pend", pending, 8'h00);
    chk("rst_ovr", overrun, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_ir", ir_out, 8'h00);
      chk("idle_pend", pending, 8'h00);
      chk("idle_ovr", overrun, 8'h00);
    end
    rst = 1'b1;
    pol = 8'h00;
    irq_raw = 8'h80;
    edge_mode = 8'h80;
    step(2);
    rst = 1'b0;
    step(LAT + 6);
    chk("arm_pend", pending, DB == 0 ? 8'h00 : 8'h80);
    irq_raw = 8'h00;
    edge_mode = 8'h09;
    step(LAT + 2);
    chk("settle_pend", pending, 8'h00);
    irq_raw = 8'h01;
    step(PW);
    irq_raw = 8'h00;
    step(LAT - 1 - PW);
    chk("l0_early", pending, 8'h00);
    step(1);
    chk("l0_pend", pending, 8'h01);
    chk("l0_ir", ir_out, 8'h01);
    clr_valid = 1'b1;
    clr_no = 3'd0;
    step(1);
    clr_valid = 1'b0;
    chk("l0_clr_pend", pending, 8'h00);
    chk("l0_clr_ir", ir_out, 8'h00);
    step(LAT);
    pulse(8'h08);
    step(1);
    chk("l3_pend", pending, 8'h08);
    chk("l3_ovr", overrun, 8'h00);
    step(LAT);
    pulse(8'h08);
    clr_valid = 1'b1;
    clr_no = 3'd3;
    step(1);
    clr_valid = 1'b0;
    chk("same_pend", pending, 8'h08);
    chk("same_ovr", overrun, 8'h00);
    step(LAT);
    clr_valid = 1'b1;
    clr_no = 3'd5;
    step(1);
    clr_valid = 1'b0;
    chk("other_clr_pend", pending, 8'h08);
    pulse(8'h08);
    step(1);
    chk("ovr_set", overrun, 8'h08);
    chk("ovr_pend", pending, 8'h08);
    step(LAT);
    pulse(8'h08);
    clr_all = 1'b1;
    step(1);
    clr_all = 1'b0;
    chk("all_edge_pend", pending, 8'h08);
    chk("all_edge_ovr", overrun, 8'h00);
    step(LAT);
    clr_all = 1'b1;
    step(1);
    clr_all = 1'b0;
    chk("all_pend", pending, 8'h00);
    chk("all_ir", ir_out, 8'h00);
    irq_raw = 8'h20;
    for (int i = 0; i < LAT + 10; i++) begin
      step(1);
      if (i == 9) irq_raw = 8'h00;
      chk("lvl_ir", ir_out, (i >= LAT - 1 && i <= LAT + 8) ? 8'h20 : 8'h00);
      chk("lvl_pend", pending, 8'h00);
    end
    edge_mode = 8'h0D;
    step(1);
    pulse(8'h04);
    step(1);
    chk("l2_pend", pending, 8'h04);
    step(LAT);
    edge_mode = 8'h09;
    step(1);
    chk("l2_mode_pend", pending, 8'h00);
    chk("l2_mode_ir", ir_out, 8'h00);
    pol = 8'h41;
    step(1);
    chk("pol_ir", ir_out, 8'h40);
    step(LAT);
    chk("pol_pend", pending, 8'h00);
    pol = 8'h00;
    step(LAT);
    chk("pol_back_ir", ir_out, 8'h00);
    chk("pol_back_pend", pending, 8'h00);
    pulse(8'h01);
    step(1);
    step(LAT);
    pulse(8'h01);
    step(1);
    chk("mid_ovr", overrun, 8'h01);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_pend", pending, 8'h00);
    chk("mid_rst_ovr", overrun, 8'h00);
    chk("mid_rst_ir", ir_out, 8'h00);
`ifdef PICC_DEBOUNCE_EN
    step(LAT + 2);
    irq_raw = 8'h02;
    step(3);
    irq_raw = 8'h00;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch_ir", ir_out, 8'h00);
    end
    irq_raw = 8'h02;
    step(6);
    irq_raw = 8'h00;
    chk("db_early", ir_out, 8'h00);
    step(1);
    chk("db_ir", ir_out, 8'h02);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
